tx_link_ctrl: RTL
=================

Name: tx_link_ctrl

Overview:
- Parametrised next-generation JESD204B transmit link-layer sequencer for L lanes.
- Replaces the fixed octet mux with a SYNC~-driven state machine: code-group sync (CGS), 4-multiframe initial lane alignment (ILA), then user data or ramp test data.
- Emits per-lane octet plus K flag, registered, to the per-lane 8b/10b encoders downstream.
- Runs on the character clock, one octet per lane per clock.

Parameters:
- L, 2, number of lanes (1..8).
- F, 2, octets per frame.
- K, 16, frames per multiframe; F*K must be 17..256.
- ILA_MF, 4, number of ILA multiframes (fixed usage; must be >= 2).

Ports:
- clk  in  1  character clock.
- rst  in  1  reset.
- sync_n  in  1  SYNC~ from receiver, active-low sync request, already synchronous to clk.
- i_data  in  8*L  user octets, lane n at bits [8n+7:8n].
- i_test_en  in  1  selects ramp test data instead of user data in DATA state.
- i_cfg  in  8*14  ILA config octets 0..13, octet j at bits [8j+7:8j], shared by all lanes.
- o_ready  out  1  user data accepted this cycle.
- o_data  out  8*L  octet to encoder, per lane.
- o_k  out  L  K-character flag per lane.
- o_state  out  2  0=CGS, 1=ILA, 2=DATA.
- o_lmfc  out  1  one-cycle pulse when the LMFC counter is 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset values: o_data=0, o_k=0, o_ready=0, o_state=0 (CGS), o_lmfc=0. Internal LMFC counter cnt=0, multiframe counter mf=0, loss-of-sync flag=0.
- cnt: free-running 0..F*K-1, wraps to 0. It is never reset by state changes. o_lmfc is registered: high in the cycle after cnt==0.
- Output timing: o_data/o_k in cycle t+1 are derived from state, cnt, mf and inputs sampled in cycle t. Latency is 1 cycle.
- CGS: all lanes output 0xBC (K28.5), k=1.
  - If sync_n==1 and cnt==F*K-1, go to ILA with mf=0.
  - Otherwise stay in CGS.
- ILA, octet at position cnt of multiframe mf, all lanes unless noted:
  - cnt==0: 0x1C (/R/, K28.0), k=1.
  - cnt==F*K-1: 0x7C (/A/, K28.3), k=1.
  - mf==1, cnt==1: 0x9C (/Q/, K28.4), k=1.
  - mf==1, cnt==2..15: config octet j=cnt-2, k=0, with these per-lane overrides:
    - j==1: bits[4:0] are replaced by the lane index n; bits[7:5] come from i_cfg.
    - j==13: FCHK = sum mod 256 of that lane's octets j=0..12, after the LID override.
  - All other positions: octet value = cnt[7:0], k=0.
  - At cnt==F*K-1: mf increments. If mf==ILA_MF-1, go to DATA and clear mf.
- DATA, i_test_en=0:
  - o_ready is combinationally 1.
  - i_data is captured and emitted the next cycle with k=0 on all lanes.
- DATA, i_test_en=1:
  - o_ready=0.
  - Each lane outputs cnt[7:0], k=0.
  - i_test_en changes take effect on the next octet.
- o_ready is 0 in CGS and ILA.
- Loss of sync: in ILA or DATA, sync_n sampled 0 on two consecutive cycles moves the block to CGS. The next output is 0xBC and mf is cleared. A single-cycle low on sync_n is ignored.
- Simultaneous events: the loss-of-sync transition has priority over the ILA->DATA transition at the same edge.
- o_state reflects the state registered in the same cycle as the corresponding o_data.
- rst asserted mid-operation: all registers return to reset values immediately. After release the block restarts in CGS at cnt=0.

Test Plan:
1. L=2, F=2, K=16; reset, hold sync_n=0 for 100 cycles -> both lanes 0xBC, k=1, o_ready=0, o_lmfc pulses every 32 cycles.
2. Raise sync_n when cnt=5 -> CGS persists until cnt=31. ILA octets begin the next cycle: first 0x1C k=1, last octet of each multiframe 0x7C k=1. After exactly 128 ILA octets, o_state=2.
3. i_cfg octet1=0xE3, other config octets 0x01 -> multiframe 1 shows /Q/ at position 1. Lane0 cfg octet1=0xE0, lane1 0xE1. FCHK: lane0=0xEC, lane1=0xED.
4. In DATA, drive i_data=0xA55A (lane1=0xA5, lane0=0x5A) -> o_data=0xA55A, o_k=0 one cycle later, o_ready=1.
5. In DATA, one-cycle sync_n low -> no change. Two-cycle low -> next output 0xBC/0xBC, k=2'b11, o_state=0. Re-raise sync_n -> re-ILA at the next LMFC boundary.
6. Assert i_test_en in DATA -> o_data lanes equal the cnt ramp 0..31 wrapping, o_ready=0. Assert rst mid-ILA -> outputs 0 immediately, CGS after release.

Source files
------------

// File: rtl/tx_link_ctrl.sv
// JESD204B transmit link-layer sequencer: SYNC~-driven CGS, ILA and DATA phases
// producing one registered octet plus K flag per lane per character clock.
module tx_link_ctrl #(
    parameter int L      = 2,
    parameter int F      = 2,
    parameter int K      = 16,
    parameter int ILA_MF = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_n,
    input  logic [8*L-1:0]    i_data,
    input  logic              i_test_en,
    input  logic [8*14-1:0]   i_cfg,
    output logic              o_ready,
    output logic [8*L-1:0]    o_data,
    output logic [L-1:0]      o_k,
    output logic [1:0]        o_state,
    output logic              o_lmfc
);
    localparam int FK = F * K;
    localparam int CW = $clog2(FK);
    localparam int MW = $clog2(ILA_MF);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILA  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   mf;
    logic            sync_low_q;

    logic            last_oct;
    logic            loss;
    logic [7:0]      ramp;
    logic [7:0]      cfg_sum;
    logic [3:0]      cfg_idx;
    logic [7:0]      cfg_oct [14];
    logic [7:0]      ila_oct [L];
    logic            ila_k;

    for (genvar j = 0; j < 14; j++) begin : g_cfg
        assign cfg_oct[j] = i_cfg[8*j +: 8];
    end

    assign last_oct = (cnt == CW'(FK - 1));
    // Second consecutive low on SYNC~ outside CGS drops the link.
    assign loss     = (state != ST_CGS) && !sync_n && sync_low_q;
    assign ramp     = 8'(cnt);
    assign cfg_idx  = cnt[3:0] - 4'd2;
    assign o_ready  = (state == ST_DATA) && !i_test_en;

    // Lane-independent part of FCHK; each lane adds its own LID-patched octet 1.
    always_comb begin
        cfg_sum = 8'h00;
        for (int j = 0; j < 13; j++) begin
            if (j != 1) cfg_sum = cfg_sum + cfg_oct[j];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        ila_k = 1'b0;
        for (int n = 0; n < L; n++) ila_oct[n] = ramp;
        if (cnt == '0) begin
            ila_k = 1'b1;
            for (int n = 0; n < L; n++) ila_oct[n] = 8'h1C;
        end else if (last_oct) begin
            ila_k = 1'b1;
            for (int n = 0; n < L; n++) ila_oct[n] = 8'h7C;
        end else if (mf == MW'(1) && cnt == CW'(1)) begin
            ila_k = 1'b1;
            for (int n = 0; n < L; n++) ila_oct[n] = 8'h9C;
        end else if (mf == MW'(1) && cnt <= CW'(15)) begin
            for (int n = 0; n < L; n++) begin
                if (cfg_idx == 4'd1)
                    ila_oct[n] = {cfg_oct[1][7:5], 5'(n)};
                else if (cfg_idx == 4'd13)
                    ila_oct[n] = cfg_sum + {cfg_oct[1][7:5], 5'(n)};
                else
                    ila_oct[n] = cfg_oct[cfg_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CGS;
            cnt        <= '0;
            mf         <= '0;
            sync_low_q <= 1'b0;
            o_data     <= '0;
            o_k        <= '0;
            o_state    <= 2'd0;
            o_lmfc     <= 1'b0;
        end else begin
            cnt    <= last_oct ? '0 : cnt + 1'b1;
            o_lmfc <= (cnt == '0);
            if (loss) begin
                state      <= ST_CGS;
                mf         <= '0;
                sync_low_q <= 1'b0;
                o_data     <= {L{8'hBC}};
                o_k        <= '1;
                o_state    <= ST_CGS;
            end else begin
                sync_low_q <= (state != ST_CGS) && !sync_n;
                o_state    <= state;
                case (state)
                    ST_CGS: begin
                        o_data <= {L{8'hBC}};
                        o_k    <= '1;
                        if (sync_n && last_oct) begin
                            state <= ST_ILA;
                            mf    <= '0;
                        end
                    end
                    ST_ILA: begin
                        for (int n = 0; n < L; n++) o_data[8*n +: 8] <= ila_oct[n];
                        o_k <= {L{ila_k}};
                        if (last_oct) begin
                            if (mf == MW'(ILA_MF - 1)) begin
                                state <= ST_DATA;
                                mf    <= '0;
                            end else begin
                                mf <= mf + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        o_k    <= '0;
                        o_data <= i_test_en ? {L{ramp}} : i_data;
                    end
                    default: begin
                        state  <= ST_CGS;
                        o_data <= {L{8'hBC}};
                        o_k    <= '1;
                    end
                endcase
            end
        end
    end

endmodule
